// File: rtl/ps2_scancode_fifo_if.sv
// Connection bundle between the PS/2 receiver / CPU register path and the scancode FIFO.
// The master drives receive events and read/flush strobes; the slave (FIFO) drives the head.
interface ps2_scancode_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic                  scan_received;
  logic [7:0]            scancode;
  logic                  extended;
  logic                  released;
  logic                  rd;
  logic                  clear;
  logic [7:0]            dout;
  logic                  dout_ext;
  logic                  dout_rls;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  new_data;

  modport master (
    output scan_received, scancode, extended, released, rd, clear,
    input  dout, dout_ext, dout_rls, empty, full, count, overflow, new_data
  );

  modport slave (
    input  scan_received, scancode, extended, released, rd, clear,
    output dout, dout_ext, dout_rls, empty, full, count, overflow, new_data
  );
endinterface

// File: rtl/ps2_scancode_fifo.sv
// Circular buffer of {released, extended, scancode} events; one entry pops when the CPU's
// level read strobe falls. Asynchronous-read storage keeps the head valid throughout a read.
module ps2_scancode_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  ps2_scancode_fifo_if.slave        bus_io
);
  localparam int unsigned            Depth     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0]  PtrOne    = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]    CntOne    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]    FullCount = (DEPTH_LOG2 + 1)'(Depth);

  logic [9:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  new_data_q, new_data_d;
  logic                  rd_q, rd_d;

  logic                  empty, full;
  logic                  pop_req, do_pop, do_push, mem_we;
  logic [9:0]            head;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);

  always_comb begin
    pop_req    = rd_q & ~bus_io.rd;
    do_pop     = pop_req & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    do_push    = bus_io.scan_received & (~full | do_pop);
    mem_we     = 1'b0;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    new_data_d = 1'b0;
    rd_d       = bus_io.rd;

    if (bus_io.clear) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      mem_we     = do_push;
      new_data_d = do_push & empty;
      overflow_d = overflow_q | (bus_io.scan_received & ~do_push);
      if (do_push) wptr_d = wptr_q + PtrOne;
      if (do_pop)  rptr_d = rptr_q + PtrOne;
      if (do_push && !do_pop)      count_d = count_q + CntOne;
      else if (do_pop && !do_push) count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      new_data_q <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      new_data_q <= new_data_d;
      rd_q       <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[wptr_q] <= {bus_io.released, bus_io.extended, bus_io.scancode};
    end
  end

  assign head = mem_q[rptr_q];

  assign bus_io.dout     = empty ? 8'h00 : head[7:0];
  assign bus_io.dout_ext = empty ? 1'b0  : head[8];
  assign bus_io.dout_rls = empty ? 1'b0  : head[9];
  assign bus_io.empty    = empty;
  assign bus_io.full     = full;
  assign bus_io.count    = count_q;
  assign bus_io.overflow = overflow_q;
  assign bus_io.new_data = new_data_q;
endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Directed bench for the scancode FIFO at depth 4 with a queue-based scoreboard.
module tb_ps2_scancode_fifo;
  localparam int unsigned DL2   = 2;
  localparam int          Depth = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ps2_scancode_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

  ps2_scancode_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  logic [9:0] q[$];
  logic       exp_ovf = 1'b0;
  logic       exp_nd  = 1'b0;
  int         checks  = 0;
  int         passes  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    logic [9:0] h;
    h = (q.size() > 0) ? q[0] : 10'h000;
    chk({tag, ".dout"},     32'(bus.dout),     32'(h[7:0]));
    chk({tag, ".ext"},      32'(bus.dout_ext), 32'(h[8]));
    chk({tag, ".rls"},      32'(bus.dout_rls), 32'(h[9]));
    chk({tag, ".count"},    32'(bus.count),    32'(q.size()));
    chk({tag, ".empty"},    32'(bus.empty),    32'(q.size() == 0));
    chk({tag, ".full"},     32'(bus.full),     32'(q.size() == Depth));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(exp_ovf));
    chk({tag, ".new_data"}, 32'(bus.new_data), 32'(exp_nd));
    exp_nd = 1'b0;
  endtask

  task automatic push(input logic [7:0] code, input logic ext, input logic rls);
    bus.scan_received = 1'b1;
    bus.scancode      = code;
    bus.extended      = ext;
    bus.released      = rls;
    exp_nd = (q.size() == 0);
    if (q.size() < Depth) q.push_back({rls, ext, code});
    else exp_ovf = 1'b1;
    tick();
    bus.scan_received = 1'b0;
    bus.extended      = 1'b0;
    bus.released      = 1'b0;
    check_state("push");
  endtask

  task automatic read(input int hi);
    bus.rd = 1'b1;
    repeat (hi) begin
      tick();
      check_state("rd_hold");
    end
    bus.rd = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    tick();
    check_state("rd_end");
  endtask

  initial begin
    bus.scan_received = 1'b0;
    bus.scancode      = 8'h00;
    bus.extended      = 1'b0;
    bus.released      = 1'b0;
    bus.rd            = 1'b0;
    bus.clear         = 1'b0;

    // Reset and idle
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) begin
      tick();
      check_state("idle");
    end

    // Qualified entries in order
    push(8'h1C, 1'b0, 1'b0);
    push(8'h75, 1'b1, 1'b0);
    push(8'h1C, 1'b0, 1'b1);
    repeat (3) read(3);

    // Overflow at depth 4, sticky until clear
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b0, 1'b0);
    repeat (4) read(1);
    tick();
    check_state("ovf_sticky");
    bus.clear = 1'b1;
    exp_ovf   = 1'b0;
    tick();
    bus.clear = 1'b0;
    check_state("clear");

    // Full FIFO: push coincides with pop completion
    push(8'h11, 1'b0, 1'b0);
    push(8'h22, 1'b0, 1'b0);
    push(8'h33, 1'b0, 1'b0);
    push(8'h44, 1'b0, 1'b0);
    bus.rd = 1'b1;
    tick();
    check_state("full_rd_hold");
    bus.rd            = 1'b0;
    bus.scan_received = 1'b1;
    bus.scancode      = 8'hAA;
    void'(q.pop_front());
    q.push_back({2'b00, 8'hAA});
    tick();
    bus.scan_received = 1'b0;
    check_state("full_pop_push");
    repeat (4) read(1);

    // Empty FIFO: push coincides with an ignored pop
    bus.rd = 1'b1;
    tick();
    check_state("empty_rd_hold");
    bus.rd            = 1'b0;
    bus.scan_received = 1'b1;
    bus.scancode      = 8'h5A;
    q.push_back({2'b00, 8'h5A});
    exp_nd = 1'b1;
    tick();
    bus.scan_received = 1'b0;
    check_state("empty_pop_push");
    tick();
    check_state("nd_one_cycle");
    read(1);

    // Clear wins over a simultaneous push
    push(8'h12, 1'b0, 1'b0);
    push(8'h34, 1'b1, 1'b0);
    push(8'h56, 1'b0, 1'b1);
    bus.clear         = 1'b1;
    bus.scan_received = 1'b1;
    bus.scancode      = 8'h29;
    q.delete();
    exp_ovf = 1'b0;
    tick();
    bus.clear         = 1'b0;
    bus.scan_received = 1'b0;
    check_state("clear_push");
    read(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
